// File: rtl/vx_tcu_drl_align_pipe.sv
// Exponent alignment for the TCU DRL dot product: per-lane right shifts relative to a running group max exponent.
// Latency 2 cycles (S1 beat max, S2 group math), throughput 1 beat/cycle.
// Backpressure: elastic valid/ready; in_ready is high while S1 can advance; outputs are held while stalled.
module vx_tcu_drl_align_pipe #(
    parameter int LANES   = 5,
    parameter int EXP_W   = 10,
    parameter int SIG_W   = 25,
    parameter int SHIFT_W = 8,
    parameter int TAG_W   = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_first,
    input  logic                     in_last,
    input  logic [LANES-1:0]         in_mask,
    input  logic [LANES*EXP_W-1:0]   in_exps,
    input  logic [LANES*SIG_W-1:0]   in_sigs,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_first,
    output logic                     out_last,
    output logic [EXP_W-1:0]         out_grp_max,
    output logic [SHIFT_W-1:0]       out_acc_shift,
    output logic [LANES*SHIFT_W-1:0] out_shift,
    output logic [LANES*SIG_W-1:0]   out_sigs,
    output logic                     out_zero,
    output logic                     out_seq_err,
    output logic [TAG_W-1:0]         out_tag
);
    localparam int SMAX = (1 << SHIFT_W) - 1;
    localparam logic signed [EXP_W-1:0] EMIN = {1'b1, {(EXP_W-1){1'b0}}};

    function automatic logic signed [EXP_W:0] sdiff(input logic signed [EXP_W-1:0] a,
                                                    input logic signed [EXP_W-1:0] b);
        sdiff = $signed({a[EXP_W-1], a}) - $signed({b[EXP_W-1], b});
    endfunction

    function automatic logic [SHIFT_W-1:0] sat_shift(input logic signed [EXP_W:0] d);
        if (d < 0)
            sat_shift = '0;
        else if (int'(d) > SMAX)
            sat_shift = SHIFT_W'(SMAX);
        else
            sat_shift = SHIFT_W'(d);
    endfunction

    logic                      s1_valid, s1_first, s1_last, s1_zero;
    logic [LANES-1:0]          s1_mask;
    logic [LANES*EXP_W-1:0]    s1_exps;
    logic [LANES*SIG_W-1:0]    s1_sigs;
    logic [TAG_W-1:0]          s1_tag;
    logic signed [EXP_W-1:0]   s1_beat_max;

    logic                      grp_open;
    logic signed [EXP_W-1:0]   grp_max;

    logic                      s1_adv, s2_adv;
    logic signed [EXP_W-1:0]   beat_max;
    logic                      beat_zero;
    logic                      grp_start, seq_err;
    logic signed [EXP_W-1:0]   new_max;
    logic [SHIFT_W-1:0]        acc_shift;
    logic [LANES*SHIFT_W-1:0]  lane_shift;
    logic [LANES*SIG_W-1:0]    lane_sigs;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    always_comb begin
        beat_max  = EMIN;
        beat_zero = 1'b1;
        for (int i = 0; i < LANES; i++) begin
            if (in_mask[i]) begin
                beat_zero = 1'b0;
                if ($signed(in_exps[i*EXP_W +: EXP_W]) > beat_max)
                    beat_max = $signed(in_exps[i*EXP_W +: EXP_W]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_valid    <= 1'b0;
            s1_first    <= 1'b0;
            s1_last     <= 1'b0;
            s1_zero     <= 1'b0;
            s1_mask     <= '0;
            s1_exps     <= '0;
            s1_sigs     <= '0;
            s1_tag      <= '0;
            s1_beat_max <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_first    <= in_first;
                s1_last     <= in_last;
                s1_zero     <= beat_zero;
                s1_mask     <= in_mask;
                s1_exps     <= in_exps;
                s1_sigs     <= in_sigs;
                s1_tag      <= in_tag;
                s1_beat_max <= beat_max;
            end
        end
    end

    // A restart or an orphan beat both open a fresh group; only the flag differs.
    always_comb begin
        grp_start = s1_first || !grp_open;
        seq_err   = (s1_first == grp_open);
        if (grp_start)
            new_max = s1_beat_max;
        else if (s1_beat_max > grp_max)
            new_max = s1_beat_max;
        else
            new_max = grp_max;
        acc_shift  = grp_start ? '0 : sat_shift(sdiff(new_max, grp_max));
        lane_shift = '0;
        lane_sigs  = '0;
        for (int i = 0; i < LANES; i++) begin
            if (s1_mask[i]) begin
                lane_shift[i*SHIFT_W +: SHIFT_W] = sat_shift(sdiff(new_max, s1_exps[i*EXP_W +: EXP_W]));
                lane_sigs[i*SIG_W +: SIG_W]      = s1_sigs[i*SIG_W +: SIG_W];
            end else begin
                lane_shift[i*SHIFT_W +: SHIFT_W] = SHIFT_W'(SMAX);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid     <= 1'b0;
            grp_open      <= 1'b0;
            grp_max       <= EMIN;
            out_first     <= 1'b0;
            out_last      <= 1'b0;
            out_grp_max   <= '0;
            out_acc_shift <= '0;
            out_shift     <= '0;
            out_sigs      <= '0;
            out_zero      <= 1'b0;
            out_seq_err   <= 1'b0;
            out_tag       <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                grp_open      <= !s1_last;
                grp_max       <= new_max;
                out_first     <= s1_first;
                out_last      <= s1_last;
                out_grp_max   <= new_max;
                out_acc_shift <= acc_shift;
                out_shift     <= lane_shift;
                out_sigs      <= lane_sigs;
                out_zero      <= s1_zero;
                out_seq_err   <= seq_err;
                out_tag       <= s1_tag;
            end
        end
    end
endmodule

// File: tb/tb_vx_tcu_drl_align_pipe.sv
// Scoreboard bench for vx_tcu_drl_align_pipe: directed alignment cases plus a random backpressure run.
module tb_vx_tcu_drl_align_pipe;
    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid, in_ready, in_first, in_last;
    logic [4:0]   in_mask;
    logic [49:0]  in_exps;
    logic [124:0] in_sigs;
    logic [31:0]  in_tag;
    logic         out_valid, out_ready, out_first, out_last;
    logic [9:0]   out_grp_max;
    logic [7:0]   out_acc_shift;
    logic [39:0]  out_shift;
    logic [124:0] out_sigs;
    logic         out_zero, out_seq_err;
    logic [31:0]  out_tag;

    vx_tcu_drl_align_pipe dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first), .in_last(in_last),
        .in_mask(in_mask), .in_exps(in_exps), .in_sigs(in_sigs), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_first(out_first), .out_last(out_last),
        .out_grp_max(out_grp_max), .out_acc_shift(out_acc_shift), .out_shift(out_shift),
        .out_sigs(out_sigs), .out_zero(out_zero), .out_seq_err(out_seq_err), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           first, last, zero, err;
        logic [9:0]   gmax;
        logic [7:0]   acc;
        logic [39:0]  sh;
        logic [124:0] sig;
        logic [31:0]  tag;
    } exp_t;

    exp_t         sb[$];
    logic [9:0]   obs_max[$];
    logic [7:0]   obs_acc[$];
    logic [39:0]  obs_sh[$];
    logic [124:0] obs_sig[$];
    bit           obs_err[$];
    bit           obs_zero[$];
    int           obs_cyc[$];

    int  n_cmp = 0, n_err = 0;
    int  cyc = 0, acc_cyc = 0;
    int  m_max = -512;
    bit  m_open = 0;
    bit  mon_en = 0, bp_en = 0, hold_pend = 0;
    logic [31:0] tag_ctr = 0;
    logic [93:0] snap;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int clampi(input int d);
        return (d < 0) ? 0 : ((d > 255) ? 255 : d);
    endfunction

    function automatic logic [49:0] pe(input int a, input int b, input int c, input int d, input int e);
        logic [49:0] r;
        int v[5];
        v = '{a, b, c, d, e};
        for (int i = 0; i < 5; i++) r[i*10 +: 10] = 10'(v[i]);
        return r;
    endfunction

    task automatic push_exp(input bit f, input bit l, input logic [4:0] m, input logic [49:0] ex,
                            input logic [124:0] sg, input logic [31:0] tg);
        exp_t e;
        int bm, nm, v;
        bit st;
        bm = -512;
        e.zero = 1;
        for (int i = 0; i < 5; i++) begin
            if (m[i]) begin
                e.zero = 0;
                v = int'($signed(ex[i*10 +: 10]));
                if (v > bm) bm = v;
            end
        end
        st    = f || !m_open;
        e.err = f ? m_open : !m_open;
        nm    = st ? bm : ((bm > m_max) ? bm : m_max);
        e.acc = st ? 8'd0 : 8'(clampi(nm - m_max));
        e.sh  = '0;
        e.sig = '0;
        for (int i = 0; i < 5; i++) begin
            v = int'($signed(ex[i*10 +: 10]));
            e.sh[i*8 +: 8] = m[i] ? 8'(clampi(nm - v)) : 8'd255;
            if (m[i]) e.sig[i*25 +: 25] = sg[i*25 +: 25];
        end
        e.gmax  = 10'(nm);
        e.first = f;
        e.last  = l;
        e.tag   = tg;
        m_max   = nm;
        m_open  = !l;
        sb.push_back(e);
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input bit f, input bit l, input logic [4:0] m, input logic [49:0] ex,
                        input logic [124:0] sg);
        bit acc;
        int t;
        in_valid = 1; in_first = f; in_last = l; in_mask = m;
        in_exps = ex; in_sigs = sg; in_tag = tag_ctr;
        acc = 0;
        t = 0;
        while (!acc && t < 100) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            t++;
        end
        if (!acc) check("accept_timeout", 128'(0), 128'(1));
        else begin
            push_exp(f, l, m, ex, sg, tag_ctr);
            acc_cyc = cyc;
        end
        in_valid = 0;
        tag_ctr++;
    endtask

    task automatic clear_obs();
        obs_max.delete(); obs_acc.delete(); obs_sh.delete(); obs_sig.delete();
        obs_err.delete(); obs_zero.delete(); obs_cyc.delete();
    endtask

    task automatic wait_obs(input int n);
        int t;
        t = 0;
        while (obs_max.size() < n && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (obs_max.size() < n) check("output_timeout", 128'(obs_max.size()), 128'(n));
    endtask

    task automatic do_reset();
        reset_n = 0;
        in_valid = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        sb.delete();
        m_open = 0;
        m_max = -512;
        reset_n = 1;
    endtask

    initial begin
        out_ready = 1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!reset_n || !mon_en) hold_pend = 0;
        else begin
            check("in_ready", 128'(in_ready), 128'(!(sb.size() == 2 && !out_ready)));
            if (hold_pend) begin
                check("stall_valid", 128'(out_valid), 128'(1));
                check("stall_data", 128'({out_first, out_last, out_grp_max, out_acc_shift, out_shift,
                                          out_zero, out_seq_err, out_tag}), 128'(snap));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) check("unexpected_out", 128'(1), 128'(0));
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("first", 128'(out_first), 128'(e.first));
                    check("last", 128'(out_last), 128'(e.last));
                    check("grp_max", 128'(out_grp_max), 128'(e.gmax));
                    check("acc_shift", 128'(out_acc_shift), 128'(e.acc));
                    check("shift", 128'(out_shift), 128'(e.sh));
                    check("sigs", 128'(out_sigs), 128'(e.sig));
                    check("zero", 128'(out_zero), 128'(e.zero));
                    check("seq_err", 128'(out_seq_err), 128'(e.err));
                    check("tag", 128'(out_tag), 128'(e.tag));
                end
                obs_max.push_back(out_grp_max); obs_acc.push_back(out_acc_shift);
                obs_sh.push_back(out_shift);    obs_sig.push_back(out_sigs);
                obs_err.push_back(out_seq_err); obs_zero.push_back(out_zero);
                obs_cyc.push_back(cyc + 1);
            end
            hold_pend = out_valid && !out_ready;
            snap = {out_first, out_last, out_grp_max, out_acc_shift, out_shift, out_zero, out_seq_err, out_tag};
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [39:0]  s;
        logic [124:0] g;
        logic [124:0] sg_all;
        int rem;
        bit f;
        reset_n = 0; in_valid = 0; in_first = 0; in_last = 0;
        in_mask = 0; in_exps = 0; in_sigs = 0; in_tag = 0;
        sg_all = {5{25'h0ABCDE1}};
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1;
        mon_en = 1;
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_grp_max", 128'(out_grp_max), 128'(0));

        // single-beat group and latency
        clear_obs();
        send(1, 1, 5'b11111, pe(3, 7, -2, 7, 0), sg_all);
        wait_obs(1);
        check("t1_grp_max", 128'(obs_max[0]), 128'(7));
        check("t1_shift", 128'(obs_sh[0]), 128'(40'h07_00_09_00_04));
        check("t1_acc", 128'(obs_acc[0]), 128'(0));
        check("t1_latency", 128'(obs_cyc[0] - acc_cyc), 128'(2));

        // three-beat group
        clear_obs();
        send(1, 0, 5'b11111, pe(5, 1, -3, 5, 0), sg_all);
        send(0, 0, 5'b11111, pe(9, 2, 9, 0, -1), sg_all);
        send(0, 1, 5'b11111, pe(4, 4, 0, 1, 3), sg_all);
        wait_obs(3);
        check("t2_max0", 128'(obs_max[0]), 128'(5));
        check("t2_max1", 128'(obs_max[1]), 128'(9));
        check("t2_max2", 128'(obs_max[2]), 128'(9));
        check("t2_acc1", 128'(obs_acc[1]), 128'(4));
        check("t2_acc2", 128'(obs_acc[2]), 128'(0));
        check("t2_sh0", 128'(obs_sh[0]), 128'(40'h05_00_08_04_00));
        check("t2_sh1", 128'(obs_sh[1]), 128'(40'h0A_09_00_07_00));
        check("t2_sh2", 128'(obs_sh[2]), 128'(40'h06_08_09_05_05));

        // range clamp and masked lane
        clear_obs();
        send(1, 1, 5'b11111, pe(200, -300, 0, 0, 0), sg_all);
        send(1, 1, 5'b11110, pe(200, -300, 0, 0, 0), sg_all);
        wait_obs(2);
        s = obs_sh[0];
        check("t3_max", 128'(obs_max[0]), 128'(200));
        check("t3_lane1_clamp", 128'(s[15:8]), 128'(255));
        check("t3_lane2", 128'(s[23:16]), 128'(200));
        s = obs_sh[1];
        g = obs_sig[1];
        check("t3_masked_shift", 128'(s[7:0]), 128'(255));
        check("t3_masked_sig", 128'(g[24:0]), 128'(0));

        // all-masked beat mid-group
        clear_obs();
        send(1, 0, 5'b11111, pe(6, 2, 0, 0, 0), sg_all);
        send(0, 0, 5'b00000, pe(100, 100, 100, 100, 100), sg_all);
        send(0, 1, 5'b11111, pe(1, 1, 1, 1, 1), sg_all);
        wait_obs(3);
        check("t4_zero", 128'(obs_zero[1]), 128'(1));
        check("t4_max", 128'(obs_max[1]), 128'(6));
        check("t4_acc", 128'(obs_acc[1]), 128'(0));
        check("t4_shift", 128'(obs_sh[1]), 128'(40'hFF_FF_FF_FF_FF));
        check("t4_sig", 128'(obs_sig[1]), 128'(0));

        // framing: restart while open, then reset mid-group and orphan beat
        clear_obs();
        send(1, 0, 5'b11111, pe(4, 0, 0, 0, 0), sg_all);
        send(1, 1, 5'b11111, pe(8, 0, 0, 0, 0), sg_all);
        wait_obs(2);
        check("t6_restart_err", 128'(obs_err[1]), 128'(1));
        check("t6_restart_acc", 128'(obs_acc[1]), 128'(0));
        check("t6_restart_max", 128'(obs_max[1]), 128'(8));
        clear_obs();
        send(1, 0, 5'b11111, pe(30, 0, 0, 0, 0), sg_all);
        do_reset();
        send(0, 1, 5'b11111, pe(-5, -7, -9, -5, -20), sg_all);
        wait_obs(1);
        check("t6_orphan_err", 128'(obs_err[0]), 128'(1));
        check("t6_orphan_max", 128'(obs_max[0]), 128'(10'h3FB));
        check("t6_orphan_cnt", 128'(obs_max.size()), 128'(1));

        // random backpressure run
        bp_en = 1;
        rem = 0;
        for (int n = 0; n < 1000; n++) begin
            logic [49:0] ex;
            logic [4:0]  m;
            if (rem == 0) begin
                rem = $urandom_range(1, 4);
                f = 1;
            end else f = 0;
            if ($urandom_range(0, 19) == 0) f = !f;
            for (int i = 0; i < 5; i++)
                ex[i*10 +: 10] = 10'(($urandom_range(0, 1) == 1) ? $urandom_range(0, 1023) : $urandom_range(0, 7));
            m = ($urandom_range(0, 7) == 0) ? 5'b00000 : 5'($urandom);
            g = 125'({$urandom, $urandom, $urandom, $urandom});
            send(f, rem == 1, m, ex, g);
            rem--;
        end
        bp_en = 0;
        for (int t = 0; t < 100 && sb.size() != 0; t++) @(posedge clk);
        #1;
        check("drain", 128'(sb.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
